// File: rtl/uart_byte_rx.sv
// uart_byte_rx: oversampled UART receiver assembling LSB-first frames into bytes behind a valid/ready
// output, with framing-error pulse and sticky overrun. Define UART_BYTE_RX_PARITY_EN for an even-parity bit.
module uart_byte_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 ovr_clr,
`ifdef UART_BYTE_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_BYTE_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_cnt_next, tick_inc;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, frame_err_reg, overrun_reg, busy_reg;
  logic                 commit, ferr_next, bad_par, centre;

`ifdef UART_BYTE_RX_PARITY_EN
  logic par_bit_reg, par_bit_next, parity_err_reg, perr_next;
  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign bad_par    = ^{shift_reg, par_bit_reg};
  assign parity_err = parity_err_reg;
`else
  assign bad_par = 1'b0;
`endif

  assign tick_inc = (tick_cnt_reg == TICK_END) ? '0 : tick_cnt_reg + 1'b1;
  assign centre   = os_tick && (tick_cnt_reg == TICK_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
`ifdef UART_BYTE_RX_PARITY_EN
      par_bit_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
`ifdef UART_BYTE_RX_PARITY_EN
      par_bit_reg  <= par_bit_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    commit        = 1'b0;
    ferr_next     = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
    par_bit_next  = par_bit_reg;
    perr_next     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (os_tick && !data) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (os_tick) begin
          tick_cnt_next = tick_inc;
          // Mid start bit: a line back high was only a glitch.
          if (tick_inc == TICK_MID) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = data ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (os_tick) tick_cnt_next = tick_inc;
        if (centre) begin
          shift_next   = {data, shift_reg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
`ifdef UART_BYTE_RX_PARITY_EN
          if (bit_cnt_reg == BIT_LAST) state_next = PARITY;
`else
          if (bit_cnt_reg == BIT_LAST) state_next = STOP;
`endif
        end
      end
`ifdef UART_BYTE_RX_PARITY_EN
      PARITY: begin
        if (os_tick) tick_cnt_next = tick_inc;
        if (centre) begin
          par_bit_next = data;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (os_tick) tick_cnt_next = tick_inc;
        if (centre) begin
`ifdef UART_BYTE_RX_PARITY_EN
          perr_next = bad_par;
`endif
          if (data) begin
            commit     = !bad_par;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (os_tick && data) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      frame_err_reg <= ferr_next;
      busy_reg      <= (state_next != IDLE);
`ifdef UART_BYTE_RX_PARITY_EN
      parity_err_reg <= perr_next;
`endif
      // A commit may replace the held byte only when that byte leaves in the same cycle.
      if (commit && (!rx_valid_reg || rx_ready)) begin
        rx_data_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      if (commit && rx_valid_reg && !rx_ready) overrun_reg <= 1'b1;
      else if (ovr_clr)                        overrun_reg <= 1'b0;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: table-driven frames plus hand-written corner sequences for uart_byte_rx;
// expected bytes are queued at stimulus time and matched against observed transfers.
`timescale 1ns/1ps
module tb_uart_byte_rx;
  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_BYTE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB       = DB + PAR;
  localparam int STOP_IDX = OS + OS * NB + OS / 2 - 1;
  localparam int FRAME_T  = OS * (NB + 2);
  localparam int FULL_T   = FRAME_T + OS;

  logic       clk = 1'b0;
  logic       rst_n, data, os_tick, rx_ready, ovr_clr;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_BYTE_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_byte_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .os_tick   (os_tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
`ifdef UART_BYTE_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: observed transfers and pulse counts, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         n_vrise = 0, n_ferr = 0, n_perr = 0;
  logic       valid_d = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_ferr <= n_ferr + 1;
      if (rx_valid && !valid_d) n_vrise <= n_vrise + 1;
`ifdef UART_BYTE_RX_PARITY_EN
      if (parity_err) n_perr <= n_perr + 1;
`endif
    end
    valid_d <= rx_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic       busy_e, valid_e, valid_n, ready_pulse;
  logic       v_before, v_stop, v_next, b_stop;
  int         base_v, base_f, base_p;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       bad_par;
    int         exp_commit;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;
  vec_t tv[7];

  function automatic vec_t mk(input logic [7:0] d, input logic stop, input logic bad);
    vec_t v;
    v.d          = d;
    v.stop       = stop;
    v.bad_par    = bad;
    v.exp_commit = (stop && !(bad && PAR != 0)) ? 1 : 0;
    v.exp_ferr   = stop ? 0 : 1;
    v.exp_perr   = (bad && PAR != 0) ? 1 : 0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    logic [7:0] g;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got byte 0x%0h required none", name, g);
      end else begin
        chk(name, g, exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got no transfer required byte 0x%0h", name, exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick(input logic line);
    data    = line;
    os_tick = 1'b1;
    if (ready_pulse) rx_ready = 1'b1;
    step();
    os_tick = 1'b0;
    if (ready_pulse) rx_ready = 1'b0;
    busy_e  = busy;
    valid_e = rx_valid;
    step();
    valid_n = rx_valid;
    step();
    step();
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                           input int nticks, input logic ready_at_stop);
    logic [11:0] bits;
    bits    = 12'hFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = d[i];
    bits[1+DB] = (PAR != 0) ? ((^d) ^ bad_par) : stop;
    if (PAR != 0) bits[2+DB] = stop;
    for (int t = 0; t < nticks; t++) begin
      ready_pulse = ready_at_stop && (t == STOP_IDX);
      tick((t / OS < NB + 2) ? bits[t/OS] : 1'b1);
      ready_pulse = 1'b0;
      if (t == STOP_IDX - 1) v_before = valid_e;
      if (t == STOP_IDX) begin
        v_stop = valid_e;
        v_next = valid_n;
        b_stop = busy_e;
      end
    end
  endtask

  task automatic mark();
    base_v = n_vrise;
    base_f = n_ferr;
    base_p = n_perr;
  endtask

  initial begin
    tv[0] = mk(8'h00, 1'b1, 1'b0);
    tv[1] = mk(8'hFF, 1'b1, 1'b0);
    tv[2] = mk(8'h3C, 1'b0, 1'b0);
    tv[3] = mk(8'h81, 1'b1, 1'b0);
    tv[4] = mk(8'h5A, 1'b1, 1'b1);
    tv[5] = mk(8'hC3, 1'b1, 1'b0);
    tv[6] = mk(8'h7E, 1'b1, 1'b0);

    rst_n = 1'b0; data = 1'b1; os_tick = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0;
    ready_pulse = 1'b0;
    repeat (3) step();
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Single byte with latency and one-cycle valid under rx_ready=1.
    rx_ready = 1'b1;
    mark();
    exp_q.push_back(8'hA5);
    run_frame(8'hA5, 1'b1, 1'b0, FULL_T, 1'b0);
    chk("a5_valid_before_stop", v_before, 0);
    chk("a5_valid_after_stop", v_stop, 1);
    chk("a5_valid_one_clk", v_next, 0);
    chk("a5_busy_after_stop", b_stop, 0);
    chk("a5_frame_err", n_ferr - base_f, 0);
    chk("a5_overrun", overrun, 0);
    drain("a5_byte");

    for (int i = 0; i < 7; i++) begin
      mark();
      if (tv[i].exp_commit != 0) exp_q.push_back(tv[i].d);
      run_frame(tv[i].d, tv[i].stop, tv[i].bad_par, FULL_T, 1'b0);
      chk($sformatf("row%0d_valid_count", i), n_vrise - base_v, tv[i].exp_commit);
      chk($sformatf("row%0d_frame_err", i), n_ferr - base_f, tv[i].exp_ferr);
      chk($sformatf("row%0d_parity_err", i), n_perr - base_p, tv[i].exp_perr);
      chk($sformatf("row%0d_busy_idle", i), busy, 0);
      drain($sformatf("row%0d_byte", i));
    end

    // Start glitch: low for 4 ticks, abandoned at tick 7.
    mark();
    for (int t = 0; t < 4; t++) tick(1'b0);
    for (int t = 4; t < 7; t++) tick(1'b1);
    chk("glitch_busy_t6", busy_e, 1);
    tick(1'b1);
    chk("glitch_busy_t7", busy_e, 0);
    for (int t = 0; t < OS; t++) tick(1'b1);
    chk("glitch_valid", n_vrise - base_v, 0);
    chk("glitch_frame_err", n_ferr - base_f, 0);

    // Framing error followed by a held-low line.
    mark();
    run_frame(8'h3C, 1'b0, 1'b0, FRAME_T, 1'b0);
    for (int t = 0; t < 2 * OS; t++) tick(1'b0);
    chk("ferr_wait_busy", busy_e, 1);
    chk("ferr_count", n_ferr - base_f, 1);
    chk("ferr_valid", n_vrise - base_v, 0);
    tick(1'b1);
    chk("ferr_release_busy", busy_e, 0);
    exp_q.push_back(8'h96);
    run_frame(8'h96, 1'b1, 1'b0, FULL_T, 1'b0);
    drain("ferr_next_byte");

    // Backpressure and overrun.
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    run_frame(8'h11, 1'b1, 1'b0, FULL_T, 1'b0);
    chk("bp_first_valid", rx_valid, 1);
    chk("bp_first_data", rx_data, 8'h11);
    chk("bp_first_overrun", overrun, 0);
    run_frame(8'h22, 1'b1, 1'b0, FULL_T, 1'b0);
    chk("bp_held_data", rx_data, 8'h11);
    chk("bp_held_valid", rx_valid, 1);
    chk("bp_overrun_set", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("bp_overrun_clr", overrun, 0);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("bp_valid_fall", rx_valid, 0);
    drain("bp_byte");

    // Accept of the held byte coinciding with the next commit.
    exp_q.push_back(8'h11);
    run_frame(8'h11, 1'b1, 1'b0, FULL_T, 1'b0);
    run_frame(8'h22, 1'b1, 1'b0, FULL_T, 1'b1);
    chk("sim_data", rx_data, 8'h22);
    chk("sim_valid", rx_valid, 1);
    chk("sim_overrun", overrun, 0);
    drain("sim_byte");

    // Reset mid-frame with a held byte and overrun pending.
    run_frame(8'h33, 1'b1, 1'b0, FULL_T, 1'b0);
    chk("pre_reset_overrun", overrun, 1);
    run_frame(8'hFF, 1'b1, 1'b0, 4 * OS + 6, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rx_valid, 0);
    chk("async_rst_data", rx_data, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frame_err", frame_err, 0);
    step();
    rst_n = 1'b1;
    data  = 1'b1;
    step();
    rx_ready = 1'b1;
    mark();
    exp_q.push_back(8'h5A);
    run_frame(8'h5A, 1'b1, 1'b0, FULL_T, 1'b0);
    chk("post_reset_valid_count", n_vrise - base_v, 1);
    drain("post_reset_byte");

`ifdef UART_BYTE_RX_PARITY_EN
    mark();
    run_frame(8'h5A, 1'b1, 1'b1, FULL_T, 1'b0);
    chk("bad_parity_pulse", n_perr - base_p, 1);
    chk("bad_parity_valid", n_vrise - base_v, 0);
    chk("bad_parity_overrun", overrun, 0);
    drain("bad_parity_byte");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Downstream of the line front-end (`entry`), which delivers the synchronized/filtered RX line (`data`) and a 16x-baud oversample strobe (`uart_clk`).
- This block detects the start bit, times each bit from the oversample strobe, and assembles LSB-first 8N1 frames into bytes.
- Completed bytes go to the command decoder of the DRSSTC controller over a valid/ready handshake.
- Framing errors and overrun are flagged.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- data  input  1  synchronized RX line from `entry`; idle high.
- os_tick  input  1  one-cycle strobe at OVERSAMPLE x baud (driven by `entry` `uart_clk`).
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available.
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid && rx_ready at a clk edge.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  sticky; a byte was lost because the holding register was full.
- ovr_clr  input  1  clears overrun.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-low; one clock, `clk`. All logic is clocked by clk; os_tick only qualifies counting.
- Reset values:
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift=0.
  - rx_data=0; rx_valid=0; frame_err=0; overrun=0; busy=0.
- Reset mid-frame aborts the frame and drops any held byte.
- Tick counter: tick_cnt has width $clog2(OVERSAMPLE). It advances only on os_tick and wraps from OVERSAMPLE-1 to 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on os_tick with data=0, go to START with tick_cnt=0. A low line without os_tick is ignored.
  - START: on os_tick, increment tick_cnt. When tick_cnt reaches OVERSAMPLE/2-1 (mid start bit):
    - data=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - data=1: glitch; return to IDLE with no flags raised.
  - DATA: on the os_tick where tick_cnt=OVERSAMPLE-1 (bit centre), shift data into the MSB side, right-shifting so the first bit ends at bit 0. Then bit_cnt++ and tick_cnt=0. After DATA_BITS samples, go to STOP.
  - STOP: at the bit-centre tick:
    - data=1: commit the byte (see handshake below), go to IDLE.
    - data=0: pulse frame_err for exactly one clk, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until an os_tick with data=1, then go to IDLE. No start detection while here.
- Commit and handshake:
  - Commit with rx_valid=0 loads rx_data and sets rx_valid=1 on the following clk edge.
  - Commit in the same cycle as a handshake (rx_valid && rx_ready) loads the new byte, and rx_valid stays 1. This is not an overrun.
  - Commit with rx_valid=1 and rx_ready=0: new byte is dropped, rx_data is held, overrun=1.
  - rx_valid falls on the edge after rx_valid && rx_ready, unless a commit coincides.
  - rx_data must not change while rx_valid=1 except via the simultaneous-accept commit.
- overrun:
  - Set by an overrun event; cleared by ovr_clr.
  - If set and clear occur in the same cycle, set wins.
- Latency: rx_valid rises one clk after the stop-bit centre os_tick.
- busy is registered and equals (state != IDLE).
- data is already synchronized upstream; no additional synchronizer here.

Optional Feature:
- Macro: UART_BYTE_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit at bit centre.
  - Adds output parity_err, 1 bit: one-cycle pulse on mismatch, asserted in the same cycle the byte would commit.
  - A byte with bad parity is discarded, not committed, and does not set overrun. The FSM still checks the stop bit normally.
- Not defined: no PARITY state and no parity_err port; frame is 8N1.

Test Plan:
- Single byte: send 0xA5 8N1 at 16 os_ticks/bit, rx_ready=1 -> rx_valid high for 1 clk with rx_data=0xA5; frame_err=0; overrun=0; busy back to 0 after the stop bit.
- Start glitch: data low for 4 os_ticks, then high -> FSM returns to IDLE at tick 7; no rx_valid, no frame_err.
- Framing error: send 0x3C with stop bit=0, then hold the line low for 2 bit times -> frame_err pulses once; rx_valid stays 0; no new frame detected until the line returns high (WAIT_IDLE exercised).
- Backpressure:
  - rx_ready=0; send 0x11 then 0x22 -> rx_data=0x11 held with rx_valid=1; overrun=1 after the second stop bit.
  - Assert ovr_clr -> overrun=0.
  - Assert rx_ready -> 0x11 is transferred and rx_valid falls.
- Simultaneous accept and commit: with 0x11 held, assert rx_ready exactly in the commit cycle of 0x22 -> rx_data=0x22, rx_valid stays 1, overrun=0.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF -> all outputs are 0 asynchronously. After release, a clean 0x5A is received correctly. With UART_BYTE_RX_PARITY_EN, 0x5A sent with wrong parity -> parity_err pulses and rx_valid stays 0.
